// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
package imem_loader_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned HDR_BYTES = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } st_e;

endpackage

// File: rtl/imem_loader_packer.sv
// Byte-to-word packer: collects four big-endian bytes into a 32-bit word.
module imem_loader_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_en,
  input  logic [BYTE_W-1:0] in_byte,
  output logic [WORD_W-1:0] word_c,
  output logic              word_valid_c
);

  logic [WORD_W-BYTE_W-1:0] shift;
  logic [1:0]               cnt;

  // The completed word includes the byte being accepted this cycle.
  assign word_c       = {shift, in_byte};
  assign word_valid_c = in_en && (cnt == 2'd3);

  // Shift accepted bytes in, oldest byte ends up in the top lane.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shift <= '0;
      cnt   <= '0;
    end else if (in_en) begin
      shift <= {shift[WORD_W-2*BYTE_W-1:0], in_byte};
      cnt   <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Program loader: receives a length-prefixed byte stream and writes it
// word by word into CPU memory, holding the CPU in reset until complete.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LEN_WIDTH  = HDR_BYTES * BYTE_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BYTE_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_W-1:0]     mem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned IW = ADDR_WIDTH + 1;
  localparam int unsigned CW = ((LEN_WIDTH > IW) ? LEN_WIDTH : IW) + 1;
  localparam logic [CW-1:0] DEPTH = CW'(2 ** ADDR_WIDTH);

  st_e                  state;
  logic [LEN_WIDTH-1:0] len;
  logic [IW-1:0]        word_idx;

  logic                 xfer_c;
  logic                 load_go_c;
  logic [LEN_WIDTH-1:0] len_shift_c;
  logic                 len_too_big_c;
  logic                 last_word_c;
  logic [WORD_W-1:0]    word_c;
  logic                 word_valid_c;

  assign xfer_c        = in_valid && in_ready;
  assign load_go_c     = start && ((state == ST_IDLE) || (state == ST_DONE) ||
                                   (state == ST_ERROR));
  assign len_shift_c   = {len[LEN_WIDTH-BYTE_W-1:0], in_data};
  assign len_too_big_c = CW'(len_shift_c) > DEPTH;
  // Widened compare so a full-depth image never wraps the index.
  assign last_word_c   = (CW'(word_idx) + CW'(1)) == CW'(len);

  imem_loader_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .clear        (load_go_c),
    .in_en        (xfer_c && (state == ST_DATA)),
    .in_byte      (in_data),
    .word_c       (word_c),
    .word_valid_c (word_valid_c)
  );

  // Loader FSM with registered handshake, memory and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
      len       <= '0;
      word_idx  <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state     <= ST_LEN_HI;
            in_ready  <= 1'b1;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            len       <= '0;
          end
        end
        ST_LEN_HI: begin
          if (xfer_c) begin
            len   <= len_shift_c;
            state <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (xfer_c) begin
            len <= len_shift_c;
            if (len_shift_c == '0) begin
              state     <= ST_DONE;
              in_ready  <= 1'b0;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else if (len_too_big_c) begin
              state    <= ST_ERROR;
              in_ready <= 1'b0;
              error    <= 1'b1;
            end else begin
              state    <= ST_DATA;
              word_idx <= '0;
            end
          end
        end
        ST_DATA: begin
          if (word_valid_c) begin
            state     <= ST_WRITE;
            in_ready  <= 1'b0;
            mem_we    <= 1'b1;
            mem_addr  <= word_idx[ADDR_WIDTH-1:0];
            mem_wdata <= word_c;
          end
        end
        ST_WRITE: begin
          word_idx <= word_idx + IW'(1);
          if (last_word_c) begin
            state     <= ST_DONE;
            done      <= 1'b1;
            cpu_reset <= 1'b0;
          end else begin
            state    <= ST_DATA;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b0;
          cpu_reset <= 1'b1;
          done      <= 1'b0;
          error     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios plus random images
// compared against an expected write list derived from the frame contents.
module tb_imem_loader;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_reset;
  logic          done;
  logic          error;

  imem_loader #(.ADDR_WIDTH(AW), .LEN_WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  int            ready_bad = 0;
  bit            in_load = 1'b0;
  logic [31:0]   img [DEPTH];
  logic [31:0]   bench_mem [DEPTH];
  logic [AW-1:0] wlog_addr [$];
  logic [31:0]   wlog_data [$];

  // Observe memory writes and the in_ready/WRITE relationship during loads.
  always @(posedge clk) begin
    if (mem_we) begin
      wlog_addr.push_back(mem_addr);
      wlog_data.push_back(mem_wdata);
      bench_mem[mem_addr] = mem_wdata;
    end
    if (in_load && !done && !error && (in_ready == mem_we)) ready_bad++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present one byte (after optional random idle cycles) until it is accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    int idle;
    idle = 0;
    while (gap > 0 && $urandom_range(99) < gap && idle < 6) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom());
      @(negedge clk);
      idle++;
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      errors++;
      $error("FAIL ready_timeout observed=0 expected=1");
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom());
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8], gap);
  endtask

  task automatic wait_done(input int limit);
    int t;
    t = 0;
    while (!done && t < limit) begin
      @(negedge clk);
      t++;
    end
    check("done_wait", done, 1'b1);
  endtask

  // Full frame load of img[0..n-1], then compare the write list with the model.
  task automatic do_load(input int n, input int gap, input bit do_start);
    int bad;
    if (do_start) pulse_start();
    wlog_addr.delete();
    wlog_data.delete();
    ready_bad = 0;
    in_load   = 1'b1;
    send_byte(8'(n >> 8), gap);
    send_byte(8'(n), gap);
    for (int i = 0; i < n; i++) send_word(img[i], gap);
    wait_done(n * 8 + 64);
    in_load = 1'b0;
    check("load_cpu_reset", cpu_reset, 1'b0);
    check("load_in_ready", in_ready, 1'b0);
    check("load_wcount", wlog_addr.size(), n);
    check("load_ready_in_write", ready_bad, 0);
    bad = 0;
    for (int i = 0; i < n && i < wlog_addr.size(); i++)
      if (wlog_addr[i] !== AW'(i) || wlog_data[i] !== img[i]) bad++;
    check("load_write_list", bad, 0);
  endtask

  task automatic set_img3();
    img[0] = 32'h2002_0004;
    img[1] = 32'h2003_0005;
    img[2] = 32'h0043_1020;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1'b0);
    check({tag, "_mem_we"}, mem_we, 1'b0);
    check({tag, "_mem_addr"}, mem_addr, '0);
    check({tag, "_mem_wdata"}, mem_wdata, '0);
    check({tag, "_cpu_reset"}, cpu_reset, 1'b1);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_error"}, error, 1'b0);
  endtask

  initial begin
    int n;
    int wc;
    for (int i = 0; i < DEPTH; i++) bench_mem[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1'b0);

    // Reference three-word image
    set_img3();
    do_load(3, 0, 1'b1);
    if (wlog_addr.size() == 3) begin
      check("n3_addr0", wlog_addr[0], 0);
      check("n3_data0", wlog_data[0], 32'h2002_0004);
      check("n3_addr1", wlog_addr[1], 1);
      check("n3_data1", wlog_data[1], 32'h2003_0005);
      check("n3_addr2", wlog_addr[2], 2);
      check("n3_data2", wlog_data[2], 32'h0043_1020);
    end
    check("n3_done", done, 1'b1);
    check("n3_hold_addr", mem_addr, 2);
    check("n3_hold_wdata", mem_wdata, 32'h0043_1020);

    // Zero-length header finishes right after the second header byte
    wlog_addr.delete();
    pulse_start();
    check("n0_cpu_reset_raised", cpu_reset, 1'b1);
    check("n0_done_cleared", done, 1'b0);
    send_byte(8'h00, 0);
    check("n0_not_done_yet", done, 1'b0);
    send_byte(8'h00, 0);
    check("n0_done", done, 1'b1);
    check("n0_cpu_reset", cpu_reset, 1'b0);
    check("n0_no_write", wlog_addr.size(), 0);

    // Oversized header: one word beyond memory depth
    pulse_start();
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    check("ovf_error", error, 1'b1);
    check("ovf_cpu_reset", cpu_reset, 1'b1);
    check("ovf_in_ready", in_ready, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    check("ovf_sticky", error, 1'b1);
    check("ovf_no_write", wlog_addr.size(), 0);
    pulse_start();
    check("ovf_cleared", error, 1'b0);
    check("ovf_len_hi_ready", in_ready, 1'b1);
    img[0] = 32'hCAFE_0001;
    do_load(1, 0, 1'b0);

    // Same three-word image with random valid gaps
    set_img3();
    do_load(3, 50, 1'b1);

    // Reset after six data bytes, then a full reload
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_word(img[0], 0);
    send_byte(8'h20, 0);
    send_byte(8'h03, 0);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) bench_mem[i] = '0;
    do_load(3, 0, 1'b1);
    for (int i = 0; i < 3; i++) check("reload_mem", bench_mem[i], img[i]);

    // start during DATA is ignored; also checks write strobe timing
    img[0] = 32'h1122_3344;
    img[1] = 32'h5566_7788;
    wlog_addr.delete();
    wlog_data.delete();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_word(img[0], 0);
    check("lat_mem_we", mem_we, 1'b1);
    check("lat_addr", mem_addr, 0);
    check("lat_wdata", mem_wdata, 32'h1122_3344);
    check("lat_in_ready", in_ready, 1'b0);
    @(negedge clk);
    check("lat_we_one_cycle", mem_we, 1'b0);
    check("lat_ready_back", in_ready, 1'b1);
    send_byte(8'h55, 0);
    pulse_start();
    send_byte(8'h66, 0);
    send_byte(8'h77, 0);
    send_byte(8'h88, 0);
    wait_done(64);
    check("ign_wcount", wlog_addr.size(), 2);
    if (wlog_addr.size() == 2) begin
      check("ign_addr1", wlog_addr[1], 1);
      check("ign_data1", wlog_data[1], 32'h5566_7788);
    end

    // Restart from DONE: single word, CPU held in reset during the load
    pulse_start();
    check("redo_cpu_reset", cpu_reset, 1'b1);
    check("redo_done_clr", done, 1'b0);
    img[0] = 32'hDEAD_BEEF;
    do_load(1, 0, 1'b0);
    check("redo_mem0", bench_mem[0], 32'hDEAD_BEEF);

    // Random images with random gaps
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(16, 1);
      for (int i = 0; i < n; i++) img[i] = $urandom();
      do_load(n, 30, 1'b1);
    end

    // Full-depth image: last write lands at the top address
    for (int i = 0; i < DEPTH; i++) img[i] = $urandom();
    do_load(DEPTH, 0, 1'b1);
    if (wlog_addr.size() == DEPTH) check("full_last_addr", wlog_addr[DEPTH-1], DEPTH - 1);
    wc = 0;
    for (int i = 0; i < DEPTH; i++) if (bench_mem[i] !== img[i]) wc++;
    check("full_mem_contents", wc, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
